// File: rtl/btn_debounce_pkg.sv
// Shared types and constant helpers for the button conditioning block.
package btn_debounce_pkg;

  // Debounce FSM encoding
  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_e;

  // Milliseconds to clock cycles at the given clock frequency
  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                               input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

  // Counter width able to hold values up to and including lim
  function automatic int unsigned cnt_width(input int unsigned lim);
    return $clog2(lim) + 1;
  endfunction

endpackage

// File: rtl/btn_debounce_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input; reset value is a parameter.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Metastability filter chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/btn_debounce.sv
// Debounced active-low button level with long-press and auto-repeat pulses.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 27_000_000,
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned HOLD_MS     = 500,
  parameter int unsigned REPEAT_MS   = 100,
  parameter bit          REPEAT_EN   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic btn_clean_n,
  output logic long_press,
  output logic rpt
);

  localparam int unsigned DB_LIM   = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int unsigned HOLD_LIM = ms_to_cycles(CLK_HZ, HOLD_MS);
  localparam int unsigned REP_LIM  = ms_to_cycles(CLK_HZ, REPEAT_MS);
  localparam int unsigned HOLD_SAT = HOLD_LIM + REP_LIM;
  localparam int unsigned DB_W     = cnt_width(DB_LIM);
  localparam int unsigned HOLD_W   = cnt_width(HOLD_SAT);
  localparam int unsigned REP_W    = cnt_width(REP_LIM);
  localparam bit          DB_ONE   = (DB_LIM <= 1);

  logic              w_s;
  state_e            r_state;
  state_e            w_state_nxt;
  logic [DB_W-1:0]   r_db_cnt;
  logic [DB_W-1:0]   w_db_nxt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic [REP_W-1:0]  r_rep_cnt;
  logic [REP_W-1:0]  w_rep_nxt;
  logic              r_clean_n;
  logic              r_long;
  logic              r_rpt;
  logic              w_clean_nxt;
  logic              w_long_nxt;
  logic              w_rpt_nxt;

  logic w_db_hit;
  logic w_hold_hit;
  logic w_in_rep;
  logic w_rep_hit;
  logic w_cnt_step;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (btn_n),
    .o_q   (w_s)
  );

  // The edge that takes a counter to its limit is the one that acts on it
  assign w_db_hit   = (r_db_cnt >= DB_W'(DB_LIM - 1));
  assign w_hold_hit = (r_hold_cnt == HOLD_W'(HOLD_LIM - 1));
  assign w_in_rep   = (r_hold_cnt >= HOLD_W'(HOLD_LIM));
  assign w_rep_hit  = (r_rep_cnt >= REP_W'(REP_LIM - 1));
  // Hold time advances on every edge the button is seen held while debounced-pressed
  assign w_cnt_step = !w_s && ((r_state == ST_PRESSED) || (r_state == ST_RELEASE_WAIT));

  // State, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RELEASED;
      r_db_cnt   <= '0;
      r_hold_cnt <= '0;
      r_rep_cnt  <= '0;
      r_clean_n  <= 1'b1;
      r_long     <= 1'b0;
      r_rpt      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_db_cnt   <= w_db_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_rep_cnt  <= w_rep_nxt;
      r_clean_n  <= w_clean_nxt;
      r_long     <= w_long_nxt;
      r_rpt      <= w_rpt_nxt;
    end
  end

  // Next state and counters; an input change wins over a counter reaching its limit
  always_comb begin
    w_state_nxt = r_state;
    w_db_nxt    = r_db_cnt;
    w_hold_nxt  = r_hold_cnt;
    w_rep_nxt   = r_rep_cnt;

    if (w_cnt_step) begin
      if (r_hold_cnt < HOLD_W'(HOLD_SAT)) w_hold_nxt = r_hold_cnt + HOLD_W'(1);
      if (w_in_rep) begin
        w_rep_nxt = w_rep_hit ? '0 : r_rep_cnt + REP_W'(1);
      end else if (w_hold_hit) begin
        w_rep_nxt = '0;
      end
    end

    unique case (r_state)
      ST_RELEASED: begin
        if (!w_s) begin
          w_state_nxt = DB_ONE ? ST_PRESSED : ST_PRESS_WAIT;
          w_db_nxt    = DB_ONE ? '0 : DB_W'(1);
          w_hold_nxt  = '0;
          w_rep_nxt   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (w_s) begin
          w_state_nxt = ST_RELEASED;
          w_db_nxt    = '0;
        end else if (w_db_hit) begin
          w_state_nxt = ST_PRESSED;
          w_db_nxt    = '0;
          w_hold_nxt  = '0;
          w_rep_nxt   = '0;
        end else begin
          w_db_nxt = r_db_cnt + DB_W'(1);
        end
      end
      ST_PRESSED: begin
        if (w_s) begin
          w_state_nxt = DB_ONE ? ST_RELEASED : ST_RELEASE_WAIT;
          w_db_nxt    = DB_ONE ? '0 : DB_W'(1);
          if (DB_ONE) begin
            w_hold_nxt = '0;
            w_rep_nxt  = '0;
          end
        end
      end
      ST_RELEASE_WAIT: begin
        if (!w_s) begin
          w_state_nxt = ST_PRESSED;
          w_db_nxt    = '0;
        end else if (w_db_hit) begin
          w_state_nxt = ST_RELEASED;
          w_db_nxt    = '0;
          w_hold_nxt  = '0;
          w_rep_nxt   = '0;
        end else begin
          w_db_nxt = r_db_cnt + DB_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_RELEASED;
        w_db_nxt    = '0;
        w_hold_nxt  = '0;
        w_rep_nxt   = '0;
      end
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    w_clean_nxt = r_clean_n;
    w_long_nxt  = 1'b0;
    w_rpt_nxt   = 1'b0;
    w_clean_nxt = !((w_state_nxt == ST_PRESSED) || (w_state_nxt == ST_RELEASE_WAIT));
    w_long_nxt  = w_cnt_step && w_hold_hit;
    w_rpt_nxt   = REPEAT_EN && w_cnt_step && (w_hold_hit || (w_in_rep && w_rep_hit));
  end

  assign btn_clean_n = r_clean_n;
  assign long_press  = r_long;
  assign rpt         = r_rpt;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: latency, bounce rejection, glitch, long press, repeat, reset.
module tb_btn_debounce;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_n = 1'b1;
  logic clean_n, lp, rp;
  logic nr_clean_n, nr_lp, nr_rp;

  int n_cmp = 0;
  int n_err = 0;

  int cyc = 0;
  int t0 = 0;
  logic prev_clean = 1'b1;
  int falls, rises, lp_cnt, lp_at, nr_lp_cnt, nr_lp_at, nr_rpt_cnt;
  int rpt_q[$];

  always #5 clk = ~clk;

  btn_debounce #(
    .CLK_HZ(1_000_000), .DEBOUNCE_MS(1), .HOLD_MS(5), .REPEAT_MS(2), .REPEAT_EN(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_n),
    .btn_clean_n(clean_n), .long_press(lp), .rpt(rp)
  );

  btn_debounce #(
    .CLK_HZ(1_000_000), .DEBOUNCE_MS(1), .HOLD_MS(5), .REPEAT_MS(2), .REPEAT_EN(1'b0)
  ) dut_nr (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_n),
    .btn_clean_n(nr_clean_n), .long_press(nr_lp), .rpt(nr_rp)
  );

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    falls = 0; rises = 0; lp_cnt = 0; lp_at = -1;
    nr_lp_cnt = 0; nr_lp_at = -1; nr_rpt_cnt = 0;
    rpt_q.delete();
  endtask

  // One clock: sample 1 ns after the rising edge and log events relative to the last clean fall
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (prev_clean && !clean_n) begin falls++; t0 = cyc; end
    if (!prev_clean && clean_n) rises++;
    prev_clean = clean_n;
    if (lp) begin lp_cnt++; lp_at = cyc - t0; end
    if (rp) rpt_q.push_back(cyc - t0);
    if (nr_lp) begin nr_lp_cnt++; nr_lp_at = cyc - t0; end
    if (nr_rp) nr_rpt_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Edges until btn_clean_n changes, bounded
  task automatic wait_change(output int n);
    logic start;
    start = clean_n;
    n = 0;
    while (clean_n == start && n < 3000) begin
      step();
      n++;
    end
  endtask

  int lat, bad, got;
  int exp_rpt[4];

  initial begin
    clear_mon();
    exp_rpt[0] = 5000; exp_rpt[1] = 7000; exp_rpt[2] = 9000; exp_rpt[3] = 11000;

    // Reset held with the pin toggling
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      btn_n = ~btn_n;
      step();
      if (clean_n !== 1'b1 || lp !== 1'b0 || rp !== 1'b0) bad++;
    end
    chk_eq("rst_bad_cycles", bad, 0);
    chk_eq("rst_clean", int'(clean_n), 1);
    chk_eq("rst_lp", int'(lp), 0);
    chk_eq("rst_rpt", int'(rp), 0);
    btn_n = 1'b1;
    rst_n = 1'b1;
    run(5);

    // Clean press of 1500 cycles
    clear_mon();
    btn_n = 1'b0;
    wait_change(lat);
    chk_eq("press_latency", lat, 1002);
    run(1500 - 1002);
    btn_n = 1'b1;
    wait_change(lat);
    chk_eq("release_latency", lat, 1002);
    run(10);
    chk_eq("press_lp_count", lp_cnt, 0);
    chk_eq("press_rpt_count", rpt_q.size(), 0);
    chk_eq("press_falls", falls, 1);
    chk_eq("press_rises", rises, 1);

    // Bounce: toggle every 200 cycles for 2000 cycles, then hold low
    clear_mon();
    for (int i = 0; i < 10; i++) begin
      btn_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      run(200);
    end
    chk_eq("bounce_no_fall", falls, 0);
    btn_n = 1'b0;
    wait_change(lat);
    chk_eq("bounce_latency", lat, 1002);
    run(200);
    chk_eq("bounce_single_fall", falls, 1);
    btn_n = 1'b1;
    wait_change(lat);
    chk_eq("bounce_release_latency", lat, 1002);
    run(10);

    // Release glitch of 500 cycles while pressed pauses the hold time by 500
    clear_mon();
    btn_n = 1'b0;
    wait_change(lat);
    run(1000);
    btn_n = 1'b1;
    run(500);
    btn_n = 1'b0;
    run(5000);
    chk_eq("glitch_clean_low", int'(clean_n), 0);
    chk_eq("glitch_no_rise", rises, 0);
    chk_eq("glitch_lp_count", lp_cnt, 1);
    chk_eq("glitch_lp_at", lp_at, 5500);
    btn_n = 1'b1;
    wait_change(lat);
    chk_eq("glitch_release_latency", lat, 1002);
    run(10);
    chk_eq("glitch_rpt_count", rpt_q.size(), 1);
    got = (rpt_q.size() > 0) ? rpt_q[0] : -1;
    chk_eq("glitch_rpt_at", got, 5500);

    // Long hold of 12000 cycles
    clear_mon();
    btn_n = 1'b0;
    wait_change(lat);
    chk_eq("hold_press_latency", lat, 1002);
    run(12000 - 1002);
    btn_n = 1'b1;
    wait_change(lat);
    chk_eq("hold_release_latency", lat, 1002);
    run(3000);
    chk_eq("hold_lp_count", lp_cnt, 1);
    chk_eq("hold_lp_at", lp_at, 5000);
    chk_eq("hold_rpt_count", rpt_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      got = (i < rpt_q.size()) ? rpt_q[i] : -1;
      chk_eq($sformatf("hold_rpt_at_%0d", i), got, exp_rpt[i]);
    end
    chk_eq("norep_lp_count", nr_lp_cnt, 1);
    chk_eq("norep_lp_at", nr_lp_at, 5000);
    chk_eq("norep_rpt_count", nr_rpt_cnt, 0);

    // Reset in the middle of a press
    clear_mon();
    btn_n = 1'b0;
    wait_change(lat);
    run(100);
    chk_eq("midrst_pressed", int'(clean_n), 0);
    rst_n = 1'b0;
    #1;
    chk_eq("midrst_async_clean", int'(clean_n), 1);
    chk_eq("midrst_async_lp", int'(lp), 0);
    chk_eq("midrst_async_rpt", int'(rp), 0);
    run(3);
    rst_n = 1'b1;
    wait_change(lat);
    chk_eq("midrst_repress_latency", lat, 1002);
    btn_n = 1'b1;
    wait_change(lat);
    run(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
